// File: rtl/dcf77_encoder.sv
// DCF77 time-code transmitter: turns a BCD date/time into the 59-pulse minute frame
// plus a pulse-free minute mark, paced by the shared 10 ms clk_en strobe.
module dcf77_encoder #(
    parameter int TICKS_PER_SEC = 100,
    parameter int T0_TICKS      = 10,
    parameter int T1_TICKS      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       enable,
    input  logic       cest,
    input  logic [6:0] minute,
    input  logic [5:0] hour,
    input  logic [5:0] day,
    input  logic [2:0] weekday,
    input  logic [4:0] month,
    input  logic [7:0] year,
    output logic       tx,
    output logic [5:0] second,
    output logic       sec_strobe,
    output logic       frame_req,
    output logic       busy
);

    localparam int TW = $clog2(TICKS_PER_SEC);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] TICK_T0   = TW'(T0_TICKS);
    localparam logic [TW-1:0] TICK_T1   = TW'(T1_TICKS);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_RUN
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [TW-1:0]  r_tick, w_tick_nxt;
    logic [5:0]     r_second, w_second_nxt;
    logic           r_tx, w_tx_nxt;
    logic           r_sec_stb, w_sec_stb_nxt;
    logic           r_frame_req, w_frame_req_nxt;
    logic [58:0]    r_shift, w_shift_nxt;
    logic [58:0]    w_frame;
    logic [TW-1:0]  w_pulse_end;

    // Bit n of the frame is transmitted in second n; every field goes out LSB first.
    assign w_frame = {^{day, weekday, month, year}, year, month, weekday, day,
                      ^hour, hour, ^minute, minute,
                      1'b1, 1'b0, ~cest, cest, 17'd0};

    assign w_pulse_end = r_shift[0] ? TICK_T1 : TICK_T0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_second    <= '0;
            r_tx        <= 1'b0;
            r_sec_stb   <= 1'b0;
            r_frame_req <= 1'b0;
            r_shift     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick      <= w_tick_nxt;
            r_second    <= w_second_nxt;
            r_tx        <= w_tx_nxt;
            r_sec_stb   <= w_sec_stb_nxt;
            r_frame_req <= w_frame_req_nxt;
            r_shift     <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tick_nxt      = r_tick;
        w_second_nxt    = r_second;
        w_tx_nxt        = r_tx;
        w_sec_stb_nxt   = 1'b0;
        w_frame_req_nxt = 1'b0;
        w_shift_nxt     = r_shift;
        if (clk_en) begin
            if (r_state == S_IDLE) begin
                if (enable) begin
                    w_state_nxt     = S_GAP;
                    w_second_nxt    = 6'd59;
                    w_tick_nxt      = '0;
                    w_tx_nxt        = 1'b0;
                    w_sec_stb_nxt   = 1'b1;
                    w_frame_req_nxt = 1'b1;
                end
            end else if (!enable) begin
                // Abandon the frame outright; a restart always begins with a minute mark.
                w_state_nxt  = S_IDLE;
                w_tick_nxt   = '0;
                w_second_nxt = '0;
                w_tx_nxt     = 1'b0;
            end else if (r_tick == TICK_LAST) begin
                w_tick_nxt    = '0;
                w_sec_stb_nxt = 1'b1;
                if (r_state == S_GAP) begin
                    w_state_nxt  = S_RUN;
                    w_shift_nxt  = w_frame;
                    w_second_nxt = '0;
                    w_tx_nxt     = 1'b1;
                end else if (r_second == 6'd58) begin
                    w_state_nxt     = S_GAP;
                    w_shift_nxt     = {1'b0, r_shift[58:1]};
                    w_second_nxt    = 6'd59;
                    w_tx_nxt        = 1'b0;
                    w_frame_req_nxt = 1'b1;
                end else begin
                    w_shift_nxt  = {1'b0, r_shift[58:1]};
                    w_second_nxt = r_second + 6'd1;
                    w_tx_nxt     = 1'b1;
                end
            end else begin
                w_tick_nxt = r_tick + TICK_ONE;
                if (r_state == S_RUN && (r_tick + TICK_ONE) == w_pulse_end) begin
                    w_tx_nxt = 1'b0;
                end
            end
        end
    end

    assign tx         = r_tx;
    assign second     = r_second;
    assign sec_strobe = r_sec_stb;
    assign frame_req  = r_frame_req;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_dcf77_encoder.sv
// Directed bench for dcf77_encoder: decodes whole minute frames from pulse widths
// and exercises enable drop and asynchronous reset mid-frame.
module tb_dcf77_encoder;

    localparam int NV = 2;

    typedef struct packed {
        logic        cest;
        logic [6:0]  minute;
        logic [5:0]  hour;
        logic [5:0]  day;
        logic [2:0]  weekday;
        logic [4:0]  month;
        logic [7:0]  year;
        logic [58:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_en = 1'b0;
    logic       enable;
    logic       cest;
    logic [6:0] minute;
    logic [5:0] hour;
    logic [5:0] day;
    logic [2:0] weekday;
    logic [4:0] month;
    logic [7:0] year;
    logic       tx;
    logic [5:0] second;
    logic       sec_strobe;
    logic       frame_req;
    logic       busy;

    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_sec = 0;
    int   en_cnt = 0;

    dcf77_encoder #(
        .TICKS_PER_SEC(100),
        .T0_TICKS     (10),
        .T1_TICKS     (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .enable    (enable),
        .cest      (cest),
        .minute    (minute),
        .hour      (hour),
        .day       (day),
        .weekday   (weekday),
        .month     (month),
        .year      (year),
        .tx        (tx),
        .second    (second),
        .sec_strobe(sec_strobe),
        .frame_req (frame_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // clk_en every 4th clock, changed away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            en_cnt++;
            clk_en = (en_cnt % 4 == 0);
        end
    end

    always @(negedge clk) begin
        if (sec_strobe === 1'b1) n_sec++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, second=%0d busy=%0b", second, busy);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_strobe();
        do @(posedge clk); while (clk_en !== 1'b1);
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        cest    = v.cest;
        minute  = v.minute;
        hour    = v.hour;
        day     = v.day;
        weekday = v.weekday;
        month   = v.month;
        year    = v.year;
    endtask

    // Counts tx-high strobes until the next sec_strobe; n is the second's length in strobes.
    task automatic measure_second(output int w, output int n);
        w = 0;
        n = 0;
        do begin
            if (tx === 1'b1) w++;
            wait_strobe();
            n++;
        end while (sec_strobe !== 1'b1 && n < 300);
        if (sec_strobe !== 1'b1) check("sec_strobe_seen", {63'd0, sec_strobe}, 64'd1);
    endtask

    task automatic run_frame(input int i);
        logic [58:0] got;
        int w, n, wbad, pbad, s0;
        got  = '0;
        wbad = 0;
        pbad = 0;
        s0   = n_sec;
        for (int s = 0; s < 59; s++) begin
            if (s == 30 && i + 1 < NV) apply_vec(vecs[i+1]);
            measure_second(w, n);
            if (w == 20) got[s] = 1'b1;
            else if (w != 10) wbad++;
            if (n != 100) pbad++;
        end
        check("frame_req_at_59", {63'd0, frame_req}, 64'd1);
        check("second_is_59", {58'd0, second}, 64'd59);
        measure_second(w, n);
        check("mark_no_pulse", w, 0);
        check("mark_period", n, 100);
        check("frame_bits", {5'd0, got}, {5'd0, vecs[i].exp});
        check("pulse_widths_bad", wbad, 0);
        check("periods_bad", pbad, 0);
        check("sec_strobes_per_min", n_sec - s0, 60);
        check("second_wraps_0", {58'd0, second}, 64'd0);
    endtask

    initial begin
        int w, n;
        // frame A: 0x37 -> 1110110 P1=1; 0x12 -> 010010 P2=0; date ones = 9 -> P3=1
        vecs[0] = '{1'b0, 7'h37, 6'h12, 6'h24, 3'd3, 5'h06, 8'h25,
                    {1'b1, 8'b0010_0101, 5'b00110, 3'b011, 6'b100100, 1'b0, 6'b010010,
                     1'b1, 7'b0110111, 1'b1, 1'b0, 1'b1, 1'b0, 17'd0}};
        // frame B: 0x38 -> 3 ones P1=1; 0x13 -> 3 ones P2=1; date ones 3+3+2+4=12 -> P3=0
        vecs[1] = '{1'b1, 7'h38, 6'h13, 6'h31, 3'd7, 5'h12, 8'h99,
                    {1'b0, 8'b1001_1001, 5'b10010, 3'b111, 6'b110001, 1'b1, 6'b010011,
                     1'b1, 7'b0111000, 1'b1, 1'b0, 1'b0, 1'b1, 17'd0}};

        reset  = 1'b1;
        enable = 1'b1;
        apply_vec(vecs[0]);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {63'd0, tx}, 64'd0);
        check("rst_second", {58'd0, second}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_sec_strobe", {63'd0, sec_strobe}, 64'd0);
        check("rst_frame_req", {63'd0, frame_req}, 64'd0);

        @(negedge clk) reset = 1'b1;
        wait_strobe();
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_second", {58'd0, second}, 64'd59);
        check("start_frame_req", {63'd0, frame_req}, 64'd1);
        check("start_sec_strobe", {63'd0, sec_strobe}, 64'd1);
        check("start_tx", {63'd0, tx}, 64'd0);
        @(posedge clk);
        #1;
        check("frame_req_one_clk", {63'd0, frame_req}, 64'd0);
        measure_second(w, n);
        check("first_gap_no_pulse", w, 0);
        check("first_gap_period", n, 100);
        check("first_gap_to_0", {58'd0, second}, 64'd0);

        for (int i = 0; i < NV; i++) run_frame(i);

        // enable dropped in the middle of the 20-strobe pulse of second 25
        for (int s = 0; s < 25; s++) measure_second(w, n);
        check("at_second_25", {58'd0, second}, 64'd25);
        repeat (5) wait_strobe();
        check("tx_mid_pulse", {63'd0, tx}, 64'd1);
        enable = 1'b0;
        wait_strobe();
        check("drop_tx", {63'd0, tx}, 64'd0);
        check("drop_second", {58'd0, second}, 64'd0);
        check("drop_busy", {63'd0, busy}, 64'd0);
        repeat (20) wait_strobe();
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_tx", {63'd0, tx}, 64'd0);
        enable = 1'b1;
        wait_strobe();
        check("reen_busy", {63'd0, busy}, 64'd1);
        check("reen_second", {58'd0, second}, 64'd59);
        check("reen_frame_req", {63'd0, frame_req}, 64'd1);
        measure_second(w, n);
        check("reen_gap_no_pulse", w, 0);
        check("reen_gap_period", n, 100);

        // async reset between edges during the pulse of second 40 (a 1-bit)
        for (int s = 0; s < 40; s++) measure_second(w, n);
        check("at_second_40", {58'd0, second}, 64'd40);
        repeat (3) wait_strobe();
        check("tx_before_reset", {63'd0, tx}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_tx", {63'd0, tx}, 64'd0);
        check("async_second", {58'd0, second}, 64'd0);
        check("async_busy", {63'd0, busy}, 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("held_busy", {63'd0, busy}, 64'd0);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcf77_encoder.md
Name: dcf77_encoder

Overview:
- Generates a DCF77-format time-code pulse train (the transmit side of the existing dcf77 receiver) from a supplied date/time.
- Used as an on-board signal source: it can drive the receiver input in loopback for self-test, or drive an external antenna modulator via GPIO.
- Timing is derived from the shared 10 ms clk_en strobe. Every minute frame carries 59 amplitude-reduction pulses followed by a pulse-free minute mark.

Parameters:
TICKS_PER_SEC, 100, clk_en strobes per second
T0_TICKS, 10, pulse width of a 0-bit in strobes (100 ms)
T1_TICKS, 20, pulse width of a 1-bit in strobes (200 ms)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
clk_en  in  1  single-cycle 10 ms strobe
enable  in  1  1 = transmit frames, 0 = idle
cest  in  1  summer-time flag
minute  in  7  BCD 00-59
hour  in  6  BCD 00-23
day  in  6  BCD 01-31
weekday  in  3  1=Mon..7=Sun
month  in  5  BCD 01-12
year  in  8  BCD 00-99
tx  out  1  1 = carrier reduced (pulse active)
second  out  6  current second index 0-59
sec_strobe  out  1  one-clk pulse at the start of each second
frame_req  out  1  one-clk pulse at the start of second 59; source must present the next minute's values
busy  out  1  1 while not IDLE

Behaviour:
- Reset (async, reset=0): state=IDLE, tick_cnt=0, second=0, tx=0, sec_strobe=0, frame_req=0, busy=0, shift register=0.
- All state updates occur only on clk cycles with clk_en=1, except sec_strobe/frame_req, which are cleared on the next clk.
- States:
  - IDLE: outputs low. Transition to GAP on clk_en with enable=1. On entry to GAP: second=59, tick_cnt=0, frame_req pulses, sec_strobe pulses.
  - GAP: minute-mark second, tx stays 0. At tick_cnt==TICKS_PER_SEC-1 with clk_en:
    - latch the 59-bit frame from the inputs (the inputs need only be stable on this cycle);
    - second=0, tick_cnt=0, sec_strobe pulses, state=RUN;
    - tx<=1 (bit 0 is a pulse).
  - RUN: tick_cnt increments on every clk_en.
    - tx<=0 on the clk_en where tick_cnt+1 == (bit ? T1_TICKS : T0_TICKS). Pulse width is therefore exactly T0/T1 strobes.
    - At tick_cnt==TICKS_PER_SEC-1: tick_cnt=0, second++, shift register advances, sec_strobe pulses, and tx<=1 for the new bit.
    - When second becomes 59: state=GAP, tx stays 0, frame_req pulses.
- enable sampled 0 on any clk_en in GAP/RUN: state=IDLE, tx<=0, second=0 on that same clk_en. No partial frame continues.
- Frame bit map, indexed by second:
  - 0 = 0; 1-16 = 0; 17 = cest; 18 = ~cest; 19 = 0; 20 = 1.
  - 21-27 minute, 28 P1; 29-34 hour, 35 P2; 36-41 day; 42-44 weekday; 45-49 month; 50-57 year; 58 P3.
  - Every field is sent LSB first.
- Parity is even: P1 covers 21-27, P2 covers 29-34, P3 covers 36-57. The parity bit makes the count of ones, including itself, even.
- Inputs are not range-checked; illegal BCD is transmitted as given, with parity computed over the raw bits.
- Input changes during RUN do not affect the frame in flight.
- The frame_req to latch window is one full second (100 strobes).
- Reset asserted mid-frame forces IDLE immediately (asynchronously) and tx=0.

Test Plan:
- Reset with enable=1, clk_en every 4 clk; release reset → IDLE; first clk_en gives busy=1, second=59, frame_req=1 for 1 clk, and tx=0 for 100 strobes.
- Load minute=0x37, hour=0x12, cest=0, day=0x24, weekday=3, month=0x06, year=0x25 → decoded seconds 21-58 give 1,1,1,0,1,1,0,P1=1; hour 0,1,0,0,1,0,P2=0; P3=1; bits 17/18 = 0/1; bit 20 = 1.
- Measure pulse widths across a full frame → 0-bits high for exactly 10 strobes, 1-bits for exactly 20; second 59 has no pulse; period 100 strobes; 60 sec_strobe per minute.
- Change minute to 0x38 mid-RUN (second 30) → current frame unchanged; the value present at the end of second 59 appears in the next frame.
- Drop enable at second 25, mid-pulse → tx=0 and second=0 on that clk_en, busy=0; re-enable → restarts with the GAP second.
- Assert reset at second 40 between clk edges → tx, second, and busy are 0 immediately, without waiting for a clock edge.
- Loopback to the dcf77 receiver across two minutes → receiver sync asserts and its decoded date/time equals the loaded values, with error=0.
